rv_sync_fifo: RTL and testbench

Parametrised single-clock ready/valid FIFO, successor to the fixed 8-bit/4-deep buffer between source and sink. It adds these features:
- configurable width and depth;
- occupancy count output;
- programmable almost-full and almost-empty flags;
- synchronous flush;
- a high-water-mark register for sizing studies.

It sits between any ready/valid producer and consumer in the design.

---
 rtl/rv_sync_fifo.sv | 129 ++++++++++++
 tb/tb_rv_sync_fifo.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rv_sync_fifo.sv
// Parametrised single-clock ready/valid FIFO with occupancy count, programmable
// almost-full/almost-empty flags, synchronous flush and a high-water-mark register.
module rv_sync_fifo #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 4,
    parameter int AFULL_LEVEL  = DEPTH - 1,
    parameter int AEMPTY_LEVEL = 1,
    parameter int CW           = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    input  logic             hwm_clr,
    output logic [CW-1:0]    count,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    hwm
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [PW-1:0] PTR_ZERO = PW'(0);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LEVEL);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LEVEL);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    hwm_q, hwm_d;
    logic             push_s;
    logic             pop_s;
    logic             unused_ptr_msb_s;

    // The pointer MSBs distinguish full from empty for debug visibility; the
    // datapath relies on the count register instead.
    assign unused_ptr_msb_s = wr_ptr_q[AW] ^ rd_ptr_q[AW];

    // Handshake qualification: flush and reset block both sides, never out_ready -> in_ready.
    always_comb begin
        in_ready  = (count_q != CNT_FULL) & ~flush & ~rst;
        out_valid = (count_q != CNT_ZERO) & ~flush & ~rst;
        push_s    = in_valid & in_ready;
        pop_s     = out_valid & out_ready;
    end

    // Fall-through read of the head entry and flag compares on the count register.
    always_comb begin
        out_data     = mem_q[rd_ptr_q[AW-1:0]];
        count        = count_q;
        hwm          = hwm_q;
        almost_full  = (count_q >= AFULL_C);
        almost_empty = (count_q <= AEMPTY_C);
    end

    // Next-state for pointers and occupancy; flush wins over any handshake.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = PTR_ZERO;
            rd_ptr_d = PTR_ZERO;
            count_d  = CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // High-water mark tracks the next count; a clear reloads it (0 when flushing too).
    always_comb begin
        hwm_d = hwm_q;
        if (hwm_clr) begin
            hwm_d = count_d;
        end else if (count_d > hwm_q) begin
            hwm_d = count_d;
        end else begin
            hwm_d = hwm_q;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            count_q  <= CNT_ZERO;
            hwm_q    <= CNT_ZERO;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hwm_q    <= hwm_d;
        end
    end

    // Payload storage, intentionally left unreset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_data;
        end
    end

endmodule

// File: tb/tb_rv_sync_fifo.sv
// Self-checking bench for rv_sync_fifo (WIDTH=8, DEPTH=4, AFULL=3, AEMPTY=1):
// a vector table plus hand sequences, with a scoreboard checking payload order.
module tb_rv_sync_fifo;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       flush;
    logic       hwm_clr;
    logic [2:0] count;
    logic       almost_full;
    logic       almost_empty;
    logic [2:0] hwm;

    int checks   = 0;
    int failures = 0;

    logic [7:0] sb_q [$];
    logic [7:0] sb_exp;

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       fl;
        logic       hc;
        logic       ir;
        logic       ov;
        logic [2:0] cnt;
        logic       af;
        logic       ae;
        logic [2:0] hwm;
    } vec_t;

    vec_t vecs [13];

    rv_sync_fifo #(
        .WIDTH(8),
        .DEPTH(4),
        .AFULL_LEVEL(3),
        .AEMPTY_LEVEL(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .flush(flush),
        .hwm_clr(hwm_clr),
        .count(count),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .hwm(hwm)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge, return at the falling edge.
    task automatic apply(input logic iv, input logic [7:0] d, input logic ordy,
                         input logic fl, input logic hc, input logic r);
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        hwm_clr   = hc;
        rst       = r;
        @(negedge clk);
    endtask

    // Scoreboard: record accepted pushes, compare every pop in order.
    always @(negedge clk) begin
        if (rst || flush) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_pop_when_empty", 32'd1, 32'd0);
                end else begin
                    sb_exp = sb_q.pop_front();
                    check("sb_data", {24'd0, out_data}, {24'd0, sb_exp});
                end
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(in_data);
            end
        end
    end

    initial begin
        //                iv    d      ordy  fl    hc    ir    ov    cnt   af    ae    hwm
        vecs[0]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 3'd0};
        vecs[1]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b1, 3'd1};
        vecs[2]  = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 3'd2};
        vecs[3]  = '{1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 3'd3};
        vecs[4]  = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 3'd4};
        vecs[5]  = '{1'b1, 8'h05, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 3'd4};
        vecs[6]  = '{1'b1, 8'h05, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 3'd4};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 3'd4};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 3'd4};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0, 1'b1, 3'd4};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 3'd4};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 3'd4};
        vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 3'd0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        flush     = 1'b0;
        hwm_clr   = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        check("rst_count", {29'd0, count}, 32'd0);
        check("rst_hwm", {29'd0, hwm}, 32'd0);
        check("rst_afull", {31'd0, almost_full}, 32'd0);
        check("rst_aempty", {31'd0, almost_empty}, 32'd1);

        for (int i = 0; i < 13; i++) begin
            apply(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl, vecs[i].hc, 1'b0);
            check($sformatf("row%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].ir});
            check($sformatf("row%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].ov});
            check($sformatf("row%0d_count", i), {29'd0, count}, {29'd0, vecs[i].cnt});
            check($sformatf("row%0d_afull", i), {31'd0, almost_full}, {31'd0, vecs[i].af});
            check($sformatf("row%0d_aempty", i), {31'd0, almost_empty}, {31'd0, vecs[i].ae});
            check($sformatf("row%0d_hwm", i), {29'd0, hwm}, {29'd0, vecs[i].hwm});
        end

        // Streaming across pointer wrap: one in, one out every cycle.
        apply(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        check("stream_first_out_valid", {31'd0, out_valid}, 32'd0);
        for (int i = 1; i <= 20; i++) begin
            apply(1'b1, 8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
            check($sformatf("stream%0d_count", i), {29'd0, count}, 32'd1);
            check($sformatf("stream%0d_data", i), {24'd0, out_data}, 32'(i - 1));
        end
        apply(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        check("stream_tail_data", {24'd0, out_data}, 32'd20);
        apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("stream_end_count", {29'd0, count}, 32'd0);
        check("stream_end_out_valid", {31'd0, out_valid}, 32'd0);
        check("stream_hwm", {29'd0, hwm}, 32'd1);

        // Flush with count=3, together with both handshakes offered.
        apply(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 8'h44, 1'b1, 1'b1, 1'b0, 1'b0);
        check("flush_pre_count", {29'd0, count}, 32'd3);
        check("flush_in_ready", {31'd0, in_ready}, 32'd0);
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("flush_count", {29'd0, count}, 32'd0);
        check("flush_out_valid_after", {31'd0, out_valid}, 32'd0);
        check("flush_hwm_kept", {29'd0, hwm}, 32'd3);
        apply(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        check("post_flush_out_valid", {31'd0, out_valid}, 32'd1);
        check("post_flush_data", {24'd0, out_data}, 32'h0000_00AA);
        apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("post_flush_drained", {29'd0, count}, 32'd0);

        // hwm_clr together with flush loads zero.
        apply(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        check("flushclr_pre_count", {29'd0, count}, 32'd1);
        apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("flushclr_hwm", {29'd0, hwm}, 32'd0);
        check("flushclr_count", {29'd0, count}, 32'd0);

        // Fill to 4, pop to 2, clear hwm, then reset with data queued.
        apply(1'b1, 8'h61, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 8'h62, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 8'h63, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 8'h64, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 8'h65, 1'b1, 1'b0, 1'b0, 1'b0);
        check("hwm_full_count", {29'd0, count}, 32'd4);
        check("hwm_full_in_ready", {31'd0, in_ready}, 32'd0);
        apply(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        check("hwm_pop_count", {29'd0, count}, 32'd3);
        apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        check("hwm_before_clr", {29'd0, hwm}, 32'd4);
        apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("hwm_after_clr", {29'd0, hwm}, 32'd2);
        check("hwm_clr_count", {29'd0, count}, 32'd2);
        apply(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b1);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        apply(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("midrst_count", {29'd0, count}, 32'd0);
        check("midrst_hwm", {29'd0, hwm}, 32'd0);
        check("midrst_out_valid_after", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready_after", {31'd0, in_ready}, 32'd1);
        check("sb_leftover", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
